// File: rtl/grf_arb_pkg.sv
// -----------------------------------------------------------------------------
// grf_arb_pkg
// Shared widths and the buffered-result entry type for the GRF write arbiter.
//   REG_AW      : GRF register address width
//   DATA_W      : GRF data / instruction address width
//   grf_entry_t : one long-latency result waiting for a GRF write slot
// -----------------------------------------------------------------------------
package grf_arb_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pc;
    } grf_entry_t;
endpackage

// File: rtl/grf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// grf_write_arbiter_if
// Valid/ready channel carrying long-latency results into the GRF arbiter.
//   valid  : result present            (producer -> arbiter)
//   ready  : arbiter buffer can accept (arbiter -> producer)
//   waddr  : destination register
//   wdata  : result data
//   pc     : producing instruction address
// Modports: master = result producer, slave = arbiter.
// -----------------------------------------------------------------------------
interface grf_write_arbiter_if;
    import grf_arb_pkg::*;

    logic              valid;
    logic              ready;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc;

    modport master (output valid, waddr, wdata, pc, input ready);
    modport slave  (input valid, waddr, wdata, pc, output ready);
endinterface

// File: rtl/grf_arb_fifo.sv
// -----------------------------------------------------------------------------
// grf_arb_fifo
// DEPTH-entry synchronous FIFO of grf_entry_t with occupancy count.
//   clk, reset : clock, synchronous active-low reset (control state only)
//   push, din  : enqueue request and entry (ignored when full)
//   pop        : dequeue request (ignored when empty)
//   head       : oldest entry, valid when !empty
//   count      : occupied entries
//   empty,full : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module grf_arb_fifo
    import grf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  grf_entry_t                   din,
    input  logic                         pop,
    output grf_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    grf_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/grf_write_arbiter.sv
// -----------------------------------------------------------------------------
// grf_write_arbiter
// Shares the single GRF write port between in-order writeback (port A) and
// buffered long-latency results (port B), with a starvation guard and a
// per-register pending scoreboard for long-latency destinations.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   a_we/a_waddr/a_wdata/a_pc : pipeline writeback request
//   a_stall               : pipeline must hold WB and reissue next cycle
//   b (slave modport)     : long-latency result channel into the B FIFO
//   iss_valid/iss_addr    : long-latency issue; iss_ready = dest not pending
//   rs_addr/rt_addr       : source lookups; rs_busy/rt_busy = pending
//   grf_we/grf_waddr/grf_wdata/grf_iaddr : GRF write port (combinational)
//   fifo_count            : B FIFO occupancy
// Build option: define GRF_ARB_TRACE_EN to print every GRF write at the edge.
// -----------------------------------------------------------------------------
module grf_write_arbiter
    import grf_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         a_we,
    input  logic [REG_AW-1:0]            a_waddr,
    input  logic [DATA_W-1:0]            a_wdata,
    input  logic [DATA_W-1:0]            a_pc,
    output logic                         a_stall,
    grf_write_arbiter_if.slave           b,
    input  logic                         iss_valid,
    input  logic [REG_AW-1:0]            iss_addr,
    output logic                         iss_ready,
    input  logic [REG_AW-1:0]            rs_addr,
    input  logic [REG_AW-1:0]            rt_addr,
    output logic                         rs_busy,
    output logic                         rt_busy,
    output logic                         grf_we,
    output logic [REG_AW-1:0]            grf_waddr,
    output logic [DATA_W-1:0]            grf_wdata,
    output logic [DATA_W-1:0]            grf_iaddr,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int AGE_W = $clog2(STARVE_LIMIT+1);
    localparam int CNT_W = $clog2(DEPTH+1);

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] v);
        return (v >= AGE_W'(STARVE_LIMIT)) ? v : v + AGE_W'(1);
    endfunction

    grf_entry_t        fifo_din;
    grf_entry_t        head;
    logic [CNT_W-1:0]  cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;

    logic [AGE_W-1:0]  age_q;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_nxt;

    logic              a_req;
    logic              force_b;
    logic              b_grant;
    logic              a_grant;
    logic              iss_fire;

    always_comb begin
        fifo_din       = '0;
        fifo_din.waddr = b.waddr;
        fifo_din.wdata = b.wdata;
        fifo_din.pc    = b.pc;
    end

    // Ready ignores a same-cycle dequeue so it never depends on port A.
    assign b.ready = reset && !fifo_full;
    assign push    = b.valid && b.ready;

    grf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (b_grant),
        .head  (head),
        .count (cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign fifo_count = reset ? cnt : '0;

    // Writes to $0 are not requests, so they never stall the pipeline.
    assign a_req   = a_we && (a_waddr != '0);
    assign force_b = fifo_full || (age_q >= AGE_W'(STARVE_LIMIT));
    assign b_grant = reset && !fifo_empty && (!a_req || force_b);
    assign a_grant = reset && a_req && !b_grant;
    assign a_stall = a_req && b_grant;

    always_comb begin
        grf_we    = 1'b0;
        grf_waddr = a_waddr;
        grf_wdata = a_wdata;
        grf_iaddr = a_pc;
        if (b_grant) begin
            // A $0 head still consumes the slot but writes nothing.
            grf_we    = (head.waddr != '0);
            grf_waddr = head.waddr;
            grf_wdata = head.wdata;
            grf_iaddr = head.pc;
        end else if (a_grant) begin
            grf_we    = 1'b1;
        end
    end

    // Head wait counter: restarts for every new head.
    always_ff @(posedge clk) begin
        if (!reset || fifo_empty || b_grant) begin
            age_q <= '0;
        end else begin
            age_q <= age_sat_inc(age_q);
        end
    end

    assign iss_ready = reset && !pending_q[iss_addr];
    assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);
    assign rs_busy   = pending_q[rs_addr];
    assign rt_busy   = pending_q[rt_addr];

    // Clear first, then set, so a same-cycle issue to a draining register wins.
    always_comb begin
        pending_nxt = pending_q;
        if (b_grant && (head.waddr != '0)) pending_nxt[head.waddr] = 1'b0;
        if (iss_fire)                      pending_nxt[iss_addr]   = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

`ifdef GRF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (grf_we) $display("%d@%h: $%d <= %h", $time, grf_iaddr, grf_waddr, grf_wdata);
    end
`endif
endmodule

// File: doc/grf_write_arbiter.md
# grf_write_arbiter

Shares the single GRF write port between the in-order pipeline writeback (port A) and long-latency result producers such as mult/div or slow loads (port B). Port B results are buffered in a small FIFO and drained into idle write slots, with a starvation guard that stalls the pipeline when B has waited too long or its buffer is full. A per-register pending scoreboard tracks destinations of issued long-latency ops so the hazard logic can stall dependent reads. The block sits between the writeback stage, the long-latency units and the GRF write inputs.

## Interface
- DEPTH, 4, B FIFO entries; power of two, >= 2
- STARVE_LIMIT, 8, cycles a B head entry may wait before forcing a grant; >= 1
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (reset asserted when 0)
- a_we  in  1  pipeline writeback request
- a_waddr  in  5  pipeline destination register
- a_wdata  in  32  pipeline write data
- a_pc  in  32  pipeline instruction address
- a_stall  out  1  pipeline must hold WB stage and request this cycle
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept
- b_waddr  in  5  result destination register
- b_wdata  in  32  result data
- b_pc  in  32  producing instruction address
- iss_valid  in  1  long-latency op issued
- iss_addr  in  5  its destination register
- iss_ready  out  1  issue allowed (destination not pending)
- rs_addr, rt_addr  in  5  source lookups
- rs_busy, rt_busy  out  1  source register pending
- grf_we  out  1  GRF write enable
- grf_waddr  out  5  GRF write address
- grf_wdata  out  32  GRF write data
- grf_iaddr  out  32  instruction address for trace
- fifo_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- A request exists only when a_we=1 and a_waddr!=0; otherwise port A is idle and never stalled.
- force = (fifo_count==DEPTH) or (age>=STARVE_LIMIT). b_grant = FIFO non-empty and (no A request or force). a_grant = A request and not b_grant. a_stall = A request and b_grant.
- GRF outputs driven combinationally from the granted source; grf_we=0 when nothing granted. Head entry with waddr 0 is dequeued with grf_we=0.
- b_ready = (fifo_count<DEPTH); independent of same-cycle dequeue. Enqueue on b_valid and b_ready.
- age: counts cycles the head waits ungranted; cleared on dequeue and when empty; saturates at STARVE_LIMIT.
- Scoreboard pending[31:1]: set on iss_valid and iss_ready and iss_addr!=0; cleared when a B entry with that waddr is dequeued. Same register set and cleared in one cycle: set wins. pending[0] is constant 0.
- iss_ready = !pending[iss_addr]; iss_valid while iss_ready=0 is ignored.
- rs_busy/rt_busy = pending[rs_addr]/pending[rt_addr], combinational.
- An A write to a pending register is performed; pending is unchanged.

## Timing
- While reset=0: FIFO emptied, pending cleared, age=0; b_ready, a_stall, grf_we, iss_ready forced 0; fifo_count=0. Reset mid-operation discards queued results.
- A latency: grf_we in the request cycle; GRF updates at the next edge.
- B latency: accepted at edge N, eligible for grant in cycle N+1 (no bypass).
- Stalled A request reissues identically next cycle; at most one stall per forced B grant.

## Configuration
- GRF_ARB_TRACE_EN defined: every cycle with grf_we=1 prints "%d@%h: $%d <= %h" with $time, grf_iaddr, grf_waddr, grf_wdata, at the clock edge.
- Undefined: no simulation output; identical RTL behaviour.

## Structure
- Package grf_arb_pkg: REG_AW=5, DATA_W=32, and the entry struct {waddr, wdata, pc}.
- Sub-module grf_arb_fifo: DEPTH-entry synchronous FIFO with count, push/pop and head output. Arbitration, age counter and scoreboard stay at top level.

## Test plan
- Reset held 3 cycles with b_valid=1 -> b_ready=0, fifo_count=0; after release a B push of $8=0x11 writes $8 two edges later.
- a_we every cycle writing $2, B pushes $5=0xAB once -> A written each cycle until age reaches 8, then a_stall=1 for one cycle and $5=0xAB written.
- Four B pushes with A idle-free -> fifo_count=4, b_ready=0, next cycle force grants B and a_stall=1.
- iss_valid to $9 -> rs_addr=9 gives rs_busy=1, second issue to $9 sees iss_ready=0; B result for $9 dequeued -> rs_busy=0 next cycle.
- Issue to $9 in the same cycle a $9 B entry drains -> pending[9] stays 1.
- a_we with a_waddr=0 while B non-empty -> no stall, B granted; B entry with waddr 0 -> dequeued, grf_we=0.
